// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    FAULT   = 2'd3
  } seq_state_e;

  localparam int unsigned FAULT_DOM_W = 4;

  // Width needed to hold the largest of the hold, stagger and timeout counts.
  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned stagger,
                                            input int unsigned tmo);
    int unsigned m;
    m = hold;
    if (stagger > m) m = stagger;
    if (tmo > m) m = tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its surroundings.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_DOM = 4,
  parameter int unsigned CNT_W = 32
) ();

  logic                   restart;
  logic [N_DOM-1:0]       dom_ready;
  logic [N_DOM-1:0]       dom_rst_n;
  logic                   seq_done;
  logic                   timeout;
  logic [FAULT_DOM_W-1:0] fault_dom;
  logic [CNT_W-1:0]       cycle_cnt;

  modport master (
    output restart, dom_ready,
    input  dom_rst_n, seq_done, timeout, fault_dom, cycle_cnt
  );

  modport slave (
    input  restart, dom_ready,
    output dom_rst_n, seq_done, timeout, fault_dom, cycle_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_DOM active-low reset domains in order after a hold phase, with
// per-step stagger, optional ready gating, a per-step timeout and restart.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned      N_DOM          = 4,
  parameter int unsigned      HOLD_CYCLES    = 2,
  parameter int unsigned      STAGGER        = 8,
  parameter logic [N_DOM-1:0] WAIT_READY     = '0,
  parameter int unsigned      TIMEOUT_CYCLES = 400,
  parameter int unsigned      CNT_W          = 32
) (
  input logic              clk,
  input logic              rst,
  reset_sequencer_if.slave sif
);

  localparam int unsigned CW    = cnt_width(HOLD_CYCLES, STAGGER, TIMEOUT_CYCLES);
  localparam int unsigned IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CW-1:0]          step_q, step_d;
  logic [N_DOM-1:0]       rel_q, rel_d;
  logic                   done_q, done_d;
  logic                   tmo_q, tmo_d;
  logic [FAULT_DOM_W-1:0] fdom_q, fdom_d;

  logic [CW-1:0]          wait_cnt;
  logic                   advance_c;
  logic                   tmo_hit_c;
  logic                   wait_clr_c;
  logic                   cyc_clr_c;
  logic                   cyc_en_c;

  assign advance_c = (step_q >= CW'(STAGGER - 1)) &&
                     (!WAIT_READY[idx_q] || sif.dom_ready[idx_q]);
  assign tmo_hit_c = (TIMEOUT_CYCLES != 0) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter measures time spent on the current release step.
  assign wait_clr_c = sif.restart || (state_q != RELEASE) || advance_c;

  sat_counter #(.W(CW)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (wait_clr_c),
    .en_i  (state_q == RELEASE),
    .cnt_o (wait_cnt)
  );

  assign cyc_clr_c = sif.restart || (state_q == HOLD);
  assign cyc_en_c  = (state_q != HOLD);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cyc_clr_c),
    .en_i  (cyc_en_c),
    .cnt_o (sif.cycle_cnt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    rel_d   = rel_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    fdom_d  = fdom_q;

    unique case (state_q)
      HOLD: begin
        if (step_q >= CW'(HOLD_CYCLES - 1)) begin
          state_d = RELEASE;
          rel_d   = N_DOM'(1);
          idx_d   = '0;
          step_d  = '0;
        end else begin
          step_d  = step_q + CW'(1);
        end
      end
      RELEASE: begin
        // Advance takes precedence over a timeout landing on the same cycle.
        if (advance_c) begin
          step_d = '0;
          if (idx_q == IDX_W'(N_DOM - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            rel_d = rel_q | (N_DOM'(1) << (idx_q + IDX_W'(1)));
          end
        end else if (tmo_hit_c) begin
          state_d = FAULT;
          tmo_d   = 1'b1;
          fdom_d  = FAULT_DOM_W'(idx_q);
          rel_d   = '0;
          done_d  = 1'b0;
        end else if (step_q != '1) begin
          step_d = step_q + CW'(1);
        end
      end
      RUN:     ;
      FAULT:   ;
      default: state_d = HOLD;
    endcase

    if (sif.restart) begin
      state_d = HOLD;
      idx_d   = '0;
      step_d  = '0;
      rel_d   = '0;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      fdom_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
      idx_q   <= '0;
      step_q  <= '0;
      rel_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      fdom_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      fdom_q  <= fdom_d;
    end
  end

  assign sif.dom_rst_n = rel_q;
  assign sif.seq_done  = done_q;
  assign sif.timeout   = tmo_q;
  assign sif.fault_dom = fdom_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: six sequencer configurations share one clock and reset.
module tb_reset_sequencer;

  logic clk;
  logic rst;
  int   cur;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reset_sequencer_if #(.N_DOM(4), .CNT_W(32)) if0 ();
  reset_sequencer_if #(.N_DOM(4), .CNT_W(32)) if1 ();
  reset_sequencer_if #(.N_DOM(4), .CNT_W(32)) if2 ();
  reset_sequencer_if #(.N_DOM(4), .CNT_W(32)) if3 ();
  reset_sequencer_if #(.N_DOM(4), .CNT_W(32)) if4 ();
  reset_sequencer_if #(.N_DOM(4), .CNT_W(4))  if5 ();

  // u0/u4: defaults; u1: gate on domain 1; u2: gate on domain 2 with short timeout;
  // u3: timeout equal to stagger with gate on domain 0; u5: narrow cycle counter.
  reset_sequencer u0 (.clk(clk), .rst(rst), .sif(if0));
  reset_sequencer #(.WAIT_READY(4'b0010)) u1 (.clk(clk), .rst(rst), .sif(if1));
  reset_sequencer #(.WAIT_READY(4'b0100), .TIMEOUT_CYCLES(20)) u2 (.clk(clk), .rst(rst), .sif(if2));
  reset_sequencer #(.WAIT_READY(4'b0001), .TIMEOUT_CYCLES(8)) u3 (.clk(clk), .rst(rst), .sif(if3));
  reset_sequencer u4 (.clk(clk), .rst(rst), .sif(if4));
  reset_sequencer #(.CNT_W(4)) u5 (.clk(clk), .rst(rst), .sif(if5));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge n (edge 0 is the last edge with rst high).
  task automatic at_edge(input int n);
    while (cur < n) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; cur = 0;
    rst = 1'b1;
    if0.restart = 0; if0.dom_ready = '0;
    if1.restart = 0; if1.dom_ready = '0;
    if2.restart = 0; if2.dom_ready = '0;
    if3.restart = 0; if3.dom_ready = '0;
    if4.restart = 0; if4.dom_ready = '0;
    if5.restart = 0; if5.dom_ready = '0;

    @(posedge clk); #1;
    chk("rst_dom",   64'(if0.dom_rst_n), 64'h0);
    chk("rst_done",  64'(if0.seq_done),  64'h0);
    chk("rst_tmo",   64'(if0.timeout),   64'h0);
    chk("rst_fdom",  64'(if2.fault_dom), 64'h0);
    chk("rst_cnt",   64'(if0.cycle_cnt), 64'h0);
    rst = 1'b0;

    at_edge(1);  chk("u0_dom_e1",  64'(if0.dom_rst_n), 64'b0000);
    at_edge(2);  chk("u0_dom_e2",  64'(if0.dom_rst_n), 64'b0001);
                 chk("u0_cnt_e2",  64'(if0.cycle_cnt), 64'd0);
    at_edge(9);  chk("u0_dom_e9",  64'(if0.dom_rst_n), 64'b0001);
                 if3.dom_ready = 4'b0001;
    at_edge(10); chk("u0_dom_e10", 64'(if0.dom_rst_n), 64'b0011);
                 chk("u3_dom_e10", 64'(if3.dom_rst_n), 64'b0011);
                 chk("u3_tmo_e10", 64'(if3.timeout),   64'h0);
    at_edge(16); chk("u5_cnt_e16", 64'(if5.cycle_cnt), 64'd14);
    at_edge(18); chk("u0_dom_e18", 64'(if0.dom_rst_n), 64'b0111);
                 chk("u1_dom_e18", 64'(if1.dom_rst_n), 64'b0011);
    at_edge(19); chk("u4_dom_e19", 64'(if4.dom_rst_n), 64'b0111);
                 chk("u4_cnt_e19", 64'(if4.cycle_cnt), 64'd17);
                 if4.restart = 1'b1;
    at_edge(20); chk("u4_dom_rs",  64'(if4.dom_rst_n), 64'b0000);
                 chk("u4_cnt_rs",  64'(if4.cycle_cnt), 64'd0);
                 chk("u4_done_rs", 64'(if4.seq_done),  64'h0);
                 if4.restart = 1'b0;
    at_edge(21); chk("u4_dom_e21", 64'(if4.dom_rst_n), 64'b0000);
    at_edge(22); chk("u4_dom_e22", 64'(if4.dom_rst_n), 64'b0001);
    at_edge(26); chk("u0_dom_e26", 64'(if0.dom_rst_n), 64'b1111);
                 chk("u0_done_e26", 64'(if0.seq_done), 64'h0);
    at_edge(33); chk("u0_done_e33", 64'(if0.seq_done), 64'h0);
    at_edge(34); chk("u0_done_e34", 64'(if0.seq_done), 64'h1);
                 chk("u0_cnt_e34",  64'(if0.cycle_cnt), 64'd32);
                 chk("u3_done_e34", 64'(if3.seq_done), 64'h1);
                 chk("u3_tmo_e34",  64'(if3.timeout),  64'h0);
    at_edge(37); chk("u2_tmo_e37",  64'(if2.timeout),   64'h0);
                 chk("u2_dom_e37",  64'(if2.dom_rst_n), 64'b0111);
    at_edge(38); chk("u2_tmo_e38",  64'(if2.timeout),   64'h1);
                 chk("u2_fdom_e38", 64'(if2.fault_dom), 64'd2);
                 chk("u2_dom_e38",  64'(if2.dom_rst_n), 64'b0000);
                 chk("u2_done_e38", 64'(if2.seq_done),  64'h0);
    at_edge(40); chk("u5_cnt_sat",  64'(if5.cycle_cnt), 64'd15);
    at_edge(50); chk("u1_dom_e50",  64'(if1.dom_rst_n), 64'b0011);
                 if1.dom_ready = 4'b0010;
    at_edge(51); chk("u1_dom_e51",  64'(if1.dom_rst_n), 64'b0111);
    at_edge(59); chk("u1_dom_e59",  64'(if1.dom_rst_n), 64'b1111);
    at_edge(66); chk("u1_done_e66", 64'(if1.seq_done),  64'h0);
    at_edge(67); chk("u1_done_e67", 64'(if1.seq_done),  64'h1);
                 chk("u1_tmo_e67",  64'(if1.timeout),   64'h0);
    at_edge(100); chk("u4_done_e100", 64'(if4.seq_done), 64'h1);
                 if4.restart = 1'b1;
    at_edge(105); chk("u4_dom_held", 64'(if4.dom_rst_n), 64'b0000);
                 chk("u4_cnt_held", 64'(if4.cycle_cnt), 64'd0);
                 if4.restart = 1'b0;
    at_edge(106); chk("u4_dom_e106", 64'(if4.dom_rst_n), 64'b0000);
    at_edge(107); chk("u4_dom_e107", 64'(if4.dom_rst_n), 64'b0001);
    at_edge(400); chk("u2_tmo_e400",  64'(if2.timeout),   64'h1);
                 chk("u2_fdom_e400", 64'(if2.fault_dom), 64'd2);
                 chk("u2_dom_e400",  64'(if2.dom_rst_n), 64'b0000);
                 chk("u2_cnt_e400",  64'(if2.cycle_cnt), 64'd398);
                 if2.restart = 1'b1;
    at_edge(401); chk("u2_tmo_rs",  64'(if2.timeout),   64'h0);
                 chk("u2_fdom_rs", 64'(if2.fault_dom), 64'd0);
                 chk("u2_cnt_rs",  64'(if2.cycle_cnt), 64'd0);
                 chk("u2_dom_rs",  64'(if2.dom_rst_n), 64'b0000);
                 if2.restart = 1'b0;
    at_edge(403); chk("u2_dom_e403", 64'(if2.dom_rst_n), 64'b0001);
    at_edge(410); chk("u0_dom_run",  64'(if0.dom_rst_n), 64'b1111);
                 chk("u0_done_run", 64'(if0.seq_done),  64'h1);

    // Assert reset between clock edges; outputs must clear immediately.
    #3 rst = 1'b1;
    #1;
    chk("arst_dom",  64'(if0.dom_rst_n), 64'b0000);
    chk("arst_done", 64'(if0.seq_done),  64'h0);
    chk("arst_cnt",  64'(if0.cycle_cnt), 64'd0);
    chk("arst_u2",   64'(if2.dom_rst_n), 64'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Synthesizable, parametrised successor to the bench-level "release reset at cycle N, stop at cycle M" control.
- Releases N_DOM reset domains in order (e.g. CPU core, memory controller, UART), with a hold phase, a per-domain stagger and optional ready gating (e.g. DDR3 calibration done).
- Provides a per-step timeout, a fault report and a restart path.
- Sits in the top level between the board reset/button logic and the per-domain active-low resets.

Parameters:
- N_DOM, 4: number of reset domains; range 1..16.
- HOLD_CYCLES, 2: cycles all domains stay in reset after rst deasserts or after restart; must be >= 1.
- STAGGER, 8: minimum cycles between releasing domain i and advancing to i+1; must be >= 1.
- WAIT_READY, 4'b0000: per-domain mask; bit i = 1 means advancing past domain i also requires dom_ready[i].
- TIMEOUT_CYCLES, 400: maximum cycles spent on one release step; 0 disables the timeout.
- CNT_W, 32: width of cycle_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- restart  in  1  synchronous restart request, level or pulse.
- dom_ready  in  N_DOM  per-domain ready; synchronous to clk.
- dom_rst_n  out  N_DOM  active-low reset per domain.
- seq_done  out  1  all domains released, sequence complete.
- timeout  out  1  sticky fault flag.
- fault_dom  out  4  index of the domain that timed out.
- cycle_cnt  out  CNT_W  cycles since leaving HOLD; saturating.

Behaviour:
- Reset (rst = 1, asynchronous):
  - State HOLD.
  - dom_rst_n = 0, seq_done = 0, timeout = 0, fault_dom = 0, cycle_cnt = 0.
  - Internal idx, step counter and wait counter cleared.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - HOLD: step counter runs from 0. At the HOLD_CYCLES-th rising edge after rst deasserts, set dom_rst_n[0] = 1, set idx = 0, clear the counters, go to RELEASE.
  - RELEASE: the step counter and the wait counter increment each cycle.
    - Advance condition: step counter >= STAGGER - 1, and (WAIT_READY[idx] = 0 or dom_ready[idx] = 1).
    - On advance with idx < N_DOM - 1: idx increments, dom_rst_n[idx+1] = 1 on the same edge, counters clear.
    - On advance with idx = N_DOM - 1: go to RUN, seq_done = 1.
  - RUN: seq_done held at 1. dom_ready is ignored, so deasserting it has no effect.
  - FAULT: entered from RELEASE when TIMEOUT_CYCLES != 0, the wait counter equals TIMEOUT_CYCLES - 1 and the advance condition is false.
    - On entry: timeout = 1, fault_dom = idx, all dom_rst_n = 0, seq_done = 0.
    - Stays in FAULT until restart or rst.
- Simultaneous events:
  - If the advance condition and the timeout fire in the same cycle, advance wins.
  - restart has priority over every transition in every state. On the next edge: state HOLD, dom_rst_n = 0, seq_done = 0, timeout = 0, fault_dom = 0, cycle_cnt = 0, counters cleared.
  - A held restart keeps the block in HOLD with the counter held at 0.
- cycle_cnt:
  - 0 in HOLD.
  - Increments by 1 every cycle in RELEASE, RUN and FAULT.
  - Saturates at all-ones; never wraps.
- Release timing with no ready gating: dom_rst_n[i] rises at edge HOLD_CYCLES + i·STAGGER; seq_done rises at edge HOLD_CYCLES + N_DOM·STAGGER.
  - Defaults: domains release at edges 2, 10, 18, 26; seq_done at edge 34.
- Once a domain is released it stays released until FAULT, restart or rst.
- N_DOM = 1: a single RELEASE step, then RUN.

Decomposition:
- Package reset_seq_pkg:
  - State enum {HOLD, RELEASE, RUN, FAULT}, 2 bits.
  - Function for the counter width: clog2 of max(HOLD_CYCLES, STAGGER, TIMEOUT_CYCLES) + 1.
  - FAULT_DOM_W = 4.
- One natural sub-module, sat_counter (parametrised width, clear, enable, saturate). It is instantiated for cycle_cnt and for the wait counter.
- The FSM and the release vector stay in reset_sequencer.

Test Plan:
- Defaults, dom_ready = 0, rst deasserted at edge 0 → dom_rst_n = 0001 at edge 2, 0011 at 10, 0111 at 18, 1111 at 26; seq_done = 1 at 34; cycle_cnt = 32 at edge 34.
- WAIT_READY = 4'b0010, dom_ready[1] raised at edge 50 → dom_rst_n[2] rises at edge 51 (not 18); seq_done rises at edge 67.
- WAIT_READY = 4'b0100, TIMEOUT_CYCLES = 20, dom_ready = 0 → timeout = 1 and fault_dom = 2 at edge 38; dom_rst_n = 0000; state holds through edge 400.
- Timeout and ready in the same cycle: TIMEOUT_CYCLES = 8 = STAGGER, WAIT_READY[0] = 1, dom_ready[0] rises on the final wait cycle → advance wins, timeout stays 0.
- restart pulse at edge 20 (mid-RELEASE) and again in FAULT → next edge: dom_rst_n = 0000, timeout = 0, cycle_cnt = 0; resequences with dom_rst_n[0] at restart edge + 2.
- rst asserted asynchronously mid-RUN → outputs go to reset values without waiting for a clock edge; CNT_W = 4 run → cycle_cnt saturates at 15.
